// File: rtl/dbus_bridge_if.sv
// Signal bundle between the memory stage, the dbus bridge and the single-beat memory bus.
// The master modport is the bridge's view; slave is the view of the stage/bus around it.
interface dbus_bridge_if #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
);
    logic              dreq_valid;
    logic [AW-1:0]     dreq_addr;
    logic [2:0]        dreq_size;
    logic [DW/8-1:0]   dreq_strobe;
    logic [DW-1:0]     dreq_data;

    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [DW-1:0]     dresp_data;
    logic              bus_err;

    logic              mreq_valid;
    logic              mreq_write;
    logic [AW-1:0]     mreq_addr;
    logic [2:0]        mreq_size;
    logic [DW/8-1:0]   mreq_strobe;
    logic [DW-1:0]     mreq_data;

    logic              mresp_ready;
    logic              mresp_valid;
    logic [DW-1:0]     mresp_data;

    modport master (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  mresp_ready, mresp_valid, mresp_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data, bus_err,
        output mreq_valid, mreq_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
    );

    modport slave (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output mresp_ready, mresp_valid, mresp_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data, bus_err,
        input  mreq_valid, mreq_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
    );
endinterface

// File: rtl/dbus_bridge.sv
// Runs one memory-stage data-bus request at a time on a single-beat request/response bus,
// with a per-phase stall timeout that aborts the transaction and flags a bus error.
module dbus_bridge #(
    parameter int unsigned AW      = 64,
    parameter int unsigned DW      = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input logic            clk,
    input logic            reset,
    dbus_bridge_if.master  bus
);
    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [AW-1:0]     addr_q;
    logic [2:0]        size_q;
    logic [DW/8-1:0]   strobe_q;
    logic [DW-1:0]     wdata_q;
    logic [DW-1:0]     rdata_q;
    logic              err_q;

    logic              accept;
    logic              timed_out;
    logic              complete;
    logic              abort;
    logic              is_write;

    assign is_write  = |strobe_q;
    assign accept    = (state_q == StIdle) && bus.dreq_valid;
    // The stalled cycle that brings the counter up to TIMEOUT is the last one allowed.
    assign timed_out = ({1'b0, cnt_q} + 9'd1) >= TimeoutLim;
    assign complete  = (state_q == StData) && bus.mresp_valid;
    // A handshake arriving on the timeout cycle takes priority over the abort.
    assign abort     = ((state_q == StAddr) && !bus.mresp_ready && timed_out) ||
                       ((state_q == StData) && !bus.mresp_valid && timed_out);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.dreq_valid) begin
                    state_d = StAddr;
                    cnt_d   = 8'd0;
                end
            end
            StAddr: begin
                if (bus.mresp_ready) begin
                    state_d = StData;
                    cnt_d   = 8'd0;
                end else if (timed_out) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StData: begin
                if (bus.mresp_valid || timed_out) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.mreq_valid    = (state_q == StAddr);
        bus.mreq_write    = is_write;
        bus.mreq_addr     = addr_q;
        bus.mreq_size     = size_q;
        bus.mreq_strobe   = strobe_q;
        bus.mreq_data     = wdata_q;
        bus.dresp_addr_ok = (state_q == StAddr) && bus.mresp_ready;
        bus.dresp_data_ok = (state_q == StResp);
        bus.bus_err       = (state_q == StResp) && err_q;
        bus.dresp_data    = rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            size_q   <= 3'd0;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            addr_q   <= bus.dreq_addr;
            size_q   <= bus.dreq_size;
            strobe_q <= bus.dreq_strobe;
            wdata_q  <= bus.dreq_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (complete) begin
            rdata_q <= is_write ? '0 : bus.mresp_data;
            err_q   <= 1'b0;
        end else if (abort) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge: a phase-level reference model checked every cycle, plus
// literal latency/data expectations for load, store, held request, timeout and reset cases.
module tb_dbus_bridge;
    localparam int TO = 4;

    logic clk;
    logic reset;
    int   cyc;
    int   n_pass;
    int   n_total;

    dbus_bridge_if #(.AW(64), .DW(64)) bus ();

    dbus_bridge #(.AW(64), .DW(64), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference model: phase 0 waits for a request, 1 offers it to the bus, 2 waits for
    // data, 3 reports completion; stall counts cycles without progress in phases 1/2.
    int          ph;
    int          stall;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic        m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph <= 0; stall <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
            m_size <= '0; m_strobe <= '0; m_err <= 1'b0;
        end else begin
            case (ph)
                0: if (bus.dreq_valid) begin
                    ph <= 1; stall <= 0;
                    m_addr <= bus.dreq_addr; m_size <= bus.dreq_size;
                    m_strobe <= bus.dreq_strobe; m_wdata <= bus.dreq_data;
                end
                1: if (bus.mresp_ready) begin
                    ph <= 2; stall <= 0;
                end else if (stall + 1 == TO) begin
                    ph <= 3; m_err <= 1'b1; m_rdata <= '0;
                end else stall <= stall + 1;
                2: if (bus.mresp_valid) begin
                    ph <= 3; m_err <= 1'b0;
                    m_rdata <= (m_strobe != 0) ? 64'd0 : bus.mresp_data;
                end else if (stall + 1 == TO) begin
                    ph <= 3; m_err <= 1'b1; m_rdata <= '0;
                end else stall <= stall + 1;
                default: ph <= 0;
            endcase
        end
    end

    int          n_addr_ok, n_data_ok, a_cyc, d_cyc;
    logic        last_err, last_write;
    logic [63:0] last_maddr;

    always @(negedge clk) begin
        check("mreq_valid", 64'(bus.mreq_valid), 64'(ph == 1));
        check("addr_ok", 64'(bus.dresp_addr_ok), 64'(ph == 1 && bus.mresp_ready));
        check("data_ok", 64'(bus.dresp_data_ok), 64'(ph == 3));
        check("bus_err", 64'(bus.bus_err), 64'(ph == 3 && m_err));
        check("dresp_data", bus.dresp_data, m_rdata);
        check("mreq_write", 64'(bus.mreq_write), 64'(m_strobe != 0));
        check("mreq_addr", bus.mreq_addr, m_addr);
        check("mreq_size", 64'(bus.mreq_size), 64'(m_size));
        check("mreq_strobe", 64'(bus.mreq_strobe), 64'(m_strobe));
        check("mreq_data", bus.mreq_data, m_wdata);
        if (bus.dresp_addr_ok) begin n_addr_ok++; a_cyc = cyc; end
        if (bus.dresp_data_ok) begin n_data_ok++; d_cyc = cyc; last_err = bus.bus_err; end
        if (bus.mreq_valid) begin last_write = bus.mreq_write; last_maddr = bus.mreq_addr; end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_data_ok();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.dresp_data_ok) seen = 1'b1;
        end
        check("data_ok_within_bound", 64'(seen), 64'd1);
    endtask

    task automatic set_req(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
        bus.dreq_addr = a; bus.dreq_size = 3'b011; bus.dreq_strobe = s; bus.dreq_data = d;
        bus.dreq_valid = 1'b1;
    endtask

    int t0, na0, nd0;

    initial begin
        cyc = 0; n_pass = 0; n_total = 0; n_addr_ok = 0; n_data_ok = 0;
        a_cyc = 0; d_cyc = 0; last_err = 0; last_write = 0; last_maddr = '0;
        reset = 1'b0;
        bus.dreq_valid = 0; bus.dreq_addr = '0; bus.dreq_size = '0; bus.dreq_strobe = '0;
        bus.dreq_data = '0; bus.mresp_ready = 0; bus.mresp_valid = 0; bus.mresp_data = '0;
        tick(2);
        check("rst_mreq_valid", 64'(bus.mreq_valid), 64'd0);
        check("rst_dresp_data", bus.dresp_data, 64'd0);
        reset = 1'b1;
        tick(1);

        // Load, zero-wait bus
        bus.mresp_ready = 1; bus.mresp_valid = 1; bus.mresp_data = 64'h1122334455667788;
        t0 = cyc;
        set_req(64'h80000008, 8'h00, 64'h0);
        wait_data_ok();
        tick(1);
        bus.dreq_valid = 0;
        check("load_addr_ok_lat", 64'(a_cyc - t0), 64'd1);
        check("load_data_ok_lat", 64'(d_cyc - t0), 64'd3);
        check("load_data", bus.dresp_data, 64'h1122334455667788);
        check("load_write", 64'(last_write), 64'd0);

        // Store with wait states; dreq fields disturbed after acceptance
        bus.mresp_ready = 0; bus.mresp_valid = 0;
        t0 = cyc;
        set_req(64'h80000010, 8'hF0, 64'hDEADBEEF00000000);
        tick(1);
        bus.dreq_addr = 64'h1234; bus.dreq_data = 64'h5555;
        tick(2); bus.mresp_ready = 1;
        tick(1); bus.mresp_ready = 0;
        tick(2); bus.mresp_valid = 1;
        tick(1); bus.mresp_valid = 0;
        wait_data_ok();
        tick(1);
        bus.dreq_valid = 0;
        check("store_addr_ok_lat", 64'(a_cyc - t0), 64'd3);
        check("store_data_ok_lat", 64'(d_cyc - t0), 64'd7);
        check("store_data", bus.dresp_data, 64'd0);
        check("store_write", 64'(last_write), 64'd1);
        check("store_addr", last_maddr, 64'h80000010);

        // Held request: one reissue, no spurious completion
        tick(1);
        bus.mresp_ready = 1; bus.mresp_valid = 1; bus.mresp_data = 64'h0A0B0C0D01020304;
        na0 = n_addr_ok; nd0 = n_data_ok;
        set_req(64'h80000020, 8'h00, 64'h0);
        tick(6);
        bus.dreq_valid = 0;
        tick(4);
        check("held_issues", 64'(n_addr_ok - na0), 64'd2);
        check("held_data_oks", 64'(n_data_ok - nd0), 64'd2);
        check("held_data", bus.dresp_data, 64'h0A0B0C0D01020304);

        // Timeout: bus never ready
        bus.mresp_ready = 0; bus.mresp_valid = 0;
        t0 = cyc;
        set_req(64'h80000030, 8'h00, 64'h0);
        wait_data_ok();
        check("to_lat", 64'(d_cyc - t0), 64'd5);
        check("to_bus_err", 64'(last_err), 64'd1);
        check("to_data", bus.dresp_data, 64'd0);
        tick(1);
        bus.dreq_valid = 0;
        #1;
        check("to_mreq_low", 64'(bus.mreq_valid), 64'd0);
        tick(2);

        // Reset in DATA after a load left nonzero read data
        bus.mresp_ready = 1; bus.mresp_valid = 1; bus.mresp_data = 64'hCAFEF00D12345678;
        set_req(64'h80000040, 8'h00, 64'h0);
        wait_data_ok();
        tick(1);
        bus.dreq_valid = 0;
        tick(1);
        bus.mresp_valid = 0;
        set_req(64'h80000048, 8'h00, 64'h0);
        tick(2);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_mreq_valid", 64'(bus.mreq_valid), 64'd0);
        check("rst_mid_data_ok", 64'(bus.dresp_data_ok), 64'd0);
        check("rst_mid_dresp_data", bus.dresp_data, 64'd0);
        check("rst_mid_mreq_addr", bus.mreq_addr, 64'd0);
        tick(2);
        reset = 1'b1;
        bus.mresp_valid = 1; bus.mresp_data = 64'h7766554433221100;
        t0 = cyc;
        wait_data_ok();
        tick(1);
        bus.dreq_valid = 0;
        check("post_rst_lat", 64'(d_cyc - t0), 64'd3);
        check("post_rst_data", bus.dresp_data, 64'h7766554433221100);
        check("post_rst_addr", last_maddr, 64'h80000048);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
